muldiv_seq: RTL and testbench

- Iterative multi-cycle sequencer for the RV32M ops the decoder flags (decoded MUL/DIV alu_ops and funct3).
- Takes operands from the execute stage, runs a 32-step shift-add multiply or restoring divide, and returns one 32-bit result with the destination register tag.
- The pipeline stalls on busy.
- Sits beside the ALU in execute; writeback takes result/rd_out on done.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_seq.sv | 178 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 op codes,
// FSM state type and the constant results used by the divide special cases.
package muldiv_pkg;

    localparam int P_XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [P_XLEN-1:0] ALL_ONES = {P_XLEN{1'b1}};
    localparam logic [P_XLEN-1:0] INT_MIN  = {1'b1, {(P_XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: shift-add multiply step or
// restoring shift-subtract divide step on a {high, low} double-width accumulator.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = P_XLEN
) (
    input  logic                i_is_div,
    input  logic [2*XLEN-1:0]   i_acc,
    input  logic [XLEN-1:0]     i_opnd,
    output logic [2*XLEN-1:0]   o_acc
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem;
    logic [XLEN:0] w_diff;

    // Multiply: add multiplicand on the LSB, then shift right. Divide: shift left, trial subtract.
    always_comb begin
        w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, (i_acc[0] ? i_opnd : {XLEN{1'b0}})};
        w_rem  = i_acc[2*XLEN-1:XLEN-1];
        w_diff = w_rem - {1'b0, i_opnd};
        if (i_is_div) begin
            // A restored remainder is below the divisor, so its top bit is always clear.
            if (w_diff[XLEN]) begin
                o_acc = {w_rem[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
            end else begin
                o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
            end
        end else begin
            o_acc = {w_sum, i_acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (IDLE, PREP, CALC, FIX, DONE).
// Build option FAST_MUL_EN: multiplies complete in PREP with a combinational multiplier.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = P_XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [4:0]       rd_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t              r_state;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [4:0]          r_rd;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opnd;
    logic                r_neg;
    logic [CW-1:0]       r_count;
    logic                r_done;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rd_out;

    logic                w_is_div;
    logic                w_a_neg;
    logic                w_b_neg;
    logic                w_neg;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_b_zero;
    logic                w_ovf;
    logic [2*XLEN-1:0]   w_step_acc;

    // Sign-correct the magnitude result and pick the half/field the op returns.
    function automatic logic [XLEN-1:0] fix_result(input logic [2:0] f_op, input logic f_neg,
                                                   input logic [2*XLEN-1:0] f_acc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        logic [XLEN-1:0]   res;
        prod = f_neg ? -f_acc : f_acc;
        quo  = f_neg ? -f_acc[XLEN-1:0] : f_acc[XLEN-1:0];
        rem  = f_neg ? -f_acc[2*XLEN-1:XLEN] : f_acc[2*XLEN-1:XLEN];
        case (f_op)
            OP_MUL:                        res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               res = quo;
            default:                       res = rem;
        endcase
        return res;
    endfunction

    assign w_is_div = r_op[2];
    assign w_a_neg  = r_a[XLEN-1] & ((r_op == OP_MULH) || (r_op == OP_MULHSU) ||
                                     (r_op == OP_DIV)  || (r_op == OP_REM));
    assign w_b_neg  = r_b[XLEN-1] & ((r_op == OP_MULH) || (r_op == OP_DIV) || (r_op == OP_REM));
    // Remainder follows the dividend; products and quotients follow the sign xor.
    assign w_neg    = (r_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_mag_a  = w_a_neg ? -r_a : r_a;
    assign w_mag_b  = w_b_neg ? -r_b : r_b;
    assign w_b_zero = (r_b == {XLEN{1'b0}});
    assign w_ovf    = (r_a == INT_MIN) && (r_b == ALL_ONES);

    assign ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign busy   = ~ready;
    assign done   = r_done;
    assign result = r_result;
    assign rd_out = r_rd_out;

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_is_div (w_is_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_step_acc)
    );

    // Sequencer FSM with operand latch, iteration counter and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= 3'b000;
            r_a      <= {XLEN{1'b0}};
            r_b      <= {XLEN{1'b0}};
            r_rd     <= 5'd0;
            r_acc    <= {(2*XLEN){1'b0}};
            r_opnd   <= {XLEN{1'b0}};
            r_neg    <= 1'b0;
            r_count  <= {CW{1'b0}};
            r_done   <= 1'b0;
            r_result <= {XLEN{1'b0}};
            r_rd_out <= 5'd0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_rd    <= rd_in;
                        r_state <= S_PREP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    r_neg   <= w_neg;
                    r_opnd  <= w_mag_b;
                    r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                    r_count <= CNT_LAST;
                    if (w_is_div && w_b_zero) begin
                        r_result <= r_op[1] ? r_a : ALL_ONES;
                        r_rd_out <= r_rd;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_is_div && !r_op[0] && w_ovf) begin
                        r_result <= r_op[1] ? {XLEN{1'b0}} : INT_MIN;
                        r_rd_out <= r_rd;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
`ifdef FAST_MUL_EN
                    end else if (!w_is_div) begin
                        r_result <= fix_result(r_op, w_neg, w_fast_prod);
                        r_rd_out <= r_rd;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
`endif
                    end else begin
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_step_acc;
                    r_count <= r_count - CNT_ONE;
                    if (r_count == {CW{1'b0}}) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_CALC;
                    end
                end
                S_FIX: begin
                    r_result <= fix_result(r_op, r_neg, r_acc);
                    r_rd_out <= r_rd;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected result, tag and latency are queued at
// issue and compared whenever done pulses.
module tb_muldiv_seq;
    import muldiv_pkg::*;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 35;
`endif
    localparam int DIV_LAT = 35;
    localparam int SPC_LAT = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] last_exp = 32'h0;

    muldiv_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .flush  (flush),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference results computed with wide integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] m_op, input logic [31:0] m_a,
                                          input logic [31:0] m_b);
        logic signed [63:0] sa;
        logic signed [63:0] sb_;
        logic signed [63:0] sp;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        up;
        logic [31:0]        r;
        sa  = {{32{m_a[31]}}, m_a};
        sb_ = {{32{m_b[31]}}, m_b};
        ua  = {32'h0, m_a};
        ub  = {32'h0, m_b};
        case (m_op)
            OP_MUL:    begin up = ua * ub; r = up[31:0]; end
            OP_MULH:   begin sp = sa * sb_; r = sp[63:32]; end
            OP_MULHSU: begin sp = sa * $signed(ub); r = sp[63:32]; end
            OP_MULHU:  begin up = ua * ub; r = up[63:32]; end
            OP_DIV:    begin sp = sa / sb_; r = sp[31:0]; end
            OP_DIVU:   begin up = ua / ub; r = up[31:0]; end
            OP_REM:    begin sp = sa % sb_; r = sp[31:0]; end
            default:   begin up = ua % ub; r = up[31:0]; end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {31'h0, done}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                last_exp = e.res;
                check("result", result, e.res);
                check("rd_out", {27'h0, rd_out}, {27'h0, e.rd});
                check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic wait_ready();
        int g;
        g = 0;
        @(negedge clk);
        while (!ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("ready_wait", {31'h0, ready}, 32'h1);
    endtask

    task automatic issue(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                         input logic [4:0] t_rd, input logic [31:0] t_exp, input int t_lat);
        wait_ready();
        op = t_op; a = t_a; b = t_b; rd_in = t_rd; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{t_exp, t_rd, t_lat, cyc});
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain_timeout", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        int c0;
        int g;
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        op = 3'b000; a = 32'h0; b = 32'h0; rd_in = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_rd_out", {27'h0, rd_out}, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;

        issue(OP_MUL,    32'h7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, MUL_LAT);
        issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, MUL_LAT);
        issue(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, MUL_LAT);
        issue(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, MUL_LAT);
        issue(OP_DIV,    32'hFFFFFFF9, 32'h2,        5'd6,  32'hFFFFFFFD, DIV_LAT);
        issue(OP_REM,    32'hFFFFFFF9, 32'h2,        5'd7,  32'hFFFFFFFF, DIV_LAT);
        issue(OP_DIVU,   32'd100,      32'd7,        5'd8,  32'd14,       DIV_LAT);
        issue(OP_REMU,   32'd100,      32'd7,        5'd9,  32'd2,        DIV_LAT);
        issue(OP_DIV,    32'd5,        32'h0,        5'd10, 32'hFFFFFFFF, SPC_LAT);
        issue(OP_REMU,   32'd5,        32'h0,        5'd11, 32'd5,        SPC_LAT);
        issue(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, SPC_LAT);
        issue(OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h0,        SPC_LAT);
        wait_drain();

        for (int i = 0; i < 8; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom | 32'h1;
            if (r_b == 32'hFFFFFFFF) r_b = 32'h3;
            issue(r_op, r_a, r_b, 5'(i + 16), model(r_op, r_a, r_b), r_op[2] ? DIV_LAT : MUL_LAT);
        end
        wait_drain();

        // Flush during the 10th CALC cycle: no done, result held, ready right after.
        wait_ready();
        op = OP_DIVU; a = 32'd1000; b = 32'd3; rd_in = 5'd20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_ready", {31'h0, ready}, 32'h1);
        check("flush_done", {31'h0, done}, 32'h0);
        check("flush_result", result, last_exp);
        repeat (40) @(negedge clk);
        check("flush_result_late", result, last_exp);

        // Start held high while busy must not restart the op.
        wait_ready();
        op = OP_DIVU; a = 32'd9; b = 32'd3; rd_in = 5'd21; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{32'd3, 5'd21, DIV_LAT, cyc});
        op = OP_MUL; a = 32'd50; b = 32'd5; rd_in = 5'd22;
        repeat (10) @(posedge clk);
        #1 start = 1'b0;
        wait_drain();

        // Asynchronous reset in the middle of CALC.
        issue(OP_DIVU, 32'hFFFF0000, 32'd13, 5'd23, 32'hFFFF0000 / 32'd13, DIV_LAT);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_result", result, 32'h0);
        check("midrst_rd_out", {27'h0, rd_out}, 32'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(OP_MUL, 32'd6, 32'd7, 5'd24, 32'd42, MUL_LAT);
        wait_drain();

        // Back-to-back: start held into DONE is taken with no idle cycle.
        wait_ready();
        op = OP_MUL; a = 32'd6; b = 32'd7; rd_in = 5'd3; start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        sb.push_back('{32'd42, 5'd3, MUL_LAT, c0});
        sb.push_back('{32'd14, 5'd4, DIV_LAT, c0 + MUL_LAT});
        op = OP_DIVU; a = 32'd100; b = 32'd7; rd_in = 5'd4;
        g = 0;
        while (!done && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy", {31'h0, busy}, 32'h1);
        check("b2b_done_low", {31'h0, done}, 32'h0);
        wait_drain();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
